pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning the payload width (e.g. advance_pc, alu_result and reg_2_data).
REQ-002 The block SHALL have parameter CTRL_W, default 8, meaning the width of the control field (reg_write, mem_width, sign_extend, reg_src, mem_write).
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer and 0 = single register with combinational ready.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port flush_i, input, 1 bit: discard all held entries and the current input.
REQ-007 Port in_valid_i, input, 1 bit: upstream offers an entry.
REQ-008 Port in_ready_o, output, 1 bit: the block accepts an entry this cycle.
REQ-009 Port in_data_i, input, DATA_W bits: upstream payload.
REQ-010 Port in_ctrl_i, input, CTRL_W bits: upstream control field.
REQ-011 Port out_valid_o, output, 1 bit: the head entry is valid.
REQ-012 Port out_ready_i, input, 1 bit: downstream consumes the head entry this cycle.
REQ-013 Port out_data_o, output, DATA_W bits: head payload.
REQ-014 Port out_ctrl_o, output, CTRL_W bits: head control field.
REQ-015 Port count_o, output, 2 bits: number of entries held (0..2).

Function
REQ-016 Transfers SHALL occur only in cycles where valid and ready are both high on the same side.
REQ-017 With SKID=1, in_ready_o SHALL be a register output: high when count is below 2, with no combinational path from out_ready_i.
REQ-018 With SKID=1, the states SHALL be EMPTY(0), ONE(1) and TWO(2), with these transitions:
- EMPTY+accept -> ONE
- ONE+accept+no consume -> TWO
- ONE+consume+no accept -> EMPTY
- ONE+accept+consume -> ONE, new head
- TWO+consume -> ONE, skid entry moves to head
REQ-019 With SKID=0, in_ready_o SHALL equal (!out_valid_o || out_ready_i), and count_o SHALL never exceed 1.
REQ-020 Latency SHALL be one cycle: an entry accepted in cycle N appears on the outputs in cycle N+1 if the block was empty or the head is consumed in cycle N.
REQ-021 Entries SHALL leave in strict acceptance order (FIFO); nothing is duplicated or dropped except by flush.
REQ-022 While out_valid_o && !out_ready_i, out_data_o and out_ctrl_o SHALL remain stable.
REQ-023 When out_valid_o=0, out_ctrl_o SHALL be all-zero, so a bubble carries no write enables; out_data_o is then don't-care.
REQ-024 flush_i SHALL empty the block at the next edge: count 0, ctrl registers zeroed, any same-cycle input discarded.
REQ-025 flush_i SHALL take priority over accept and consume in the same cycle.
REQ-026 A same-cycle consume while flush_i is high SHALL still count as taken by downstream; the block does not re-present it.
REQ-027 rst SHALL take priority over flush_i and all handshakes.

Reset
REQ-028 While rst is high at an edge, the block SHALL drive count_o=0, out_valid_o=0, out_ctrl_o=0 and out_data_o=0.
REQ-029 While rst is high at an edge, in_ready_o SHALL be 1 from the cycle after reset for SKID=1, and SHALL follow REQ-019 for SKID=0.
REQ-030 Reset in mid-operation SHALL discard all held entries with no partial transfer.

Structure
REQ-031 The shared package SHALL hold the CTRL field bit positions, the EMPTY/ONE/TWO encodings and the default widths.
REQ-032 The block SHALL be a single module; the ex_mem/id_ex/mem_wb instances SHALL be parameterisations of it, not copies.

Verification
REQ-033 Reset then idle: after rst, out_valid_o=0, out_ctrl_o=0, count_o=0, and in_ready_o=1 (SKID=1).
REQ-034 Streaming: out_ready_i=1 and entries D=1..5 on consecutive cycles give outputs 1..5 on cycles 2..6 with no bubbles, and count_o stays at 1.
REQ-035 Backpressure: out_ready_i=0 and entries A=0xAA then B=0xBB give count_o=2, in_ready_o=0 and a stable head A; releasing out_ready_i delivers A then B in order.
REQ-036 Flush: with count 2, assert flush_i together with in_valid_i and C=0xCC; the next cycle shows count_o=0, out_valid_o=0, out_ctrl_o=0, and C never appears.
REQ-037 Simultaneous: in state ONE with accept and consume in the same cycle, the new head equals the new input and count_o stays at 1.
REQ-038 SKID=0: with out_ready_i=0 and the block full, in_ready_o=0 in the same cycle; raising out_ready_i raises in_ready_o combinationally, and the entry is replaced at the next edge.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared widths, control-field layout and occupancy encodings
package pipe_stage_pkg;

  localparam int DEFAULT_DATA_W = 96;
  localparam int DEFAULT_CTRL_W = 8;

  // Control field layout as carried between ex/mem/wb stages
  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_WIDTH_LO = 1;
  localparam int CTRL_MEM_WIDTH_HI = 2;
  localparam int CTRL_SIGN_EXTEND = 3;
  localparam int CTRL_REG_SRC_LO  = 4;
  localparam int CTRL_REG_SRC_HI  = 5;
  localparam int CTRL_MEM_WRITE   = 6;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_if.sv
// rtl/pipe_stage_if.sv - upstream/downstream handshake bundle for pipe_stage
interface pipe_stage_if #(
  parameter int DATA_W = pipe_stage_pkg::DEFAULT_DATA_W,
  parameter int CTRL_W = pipe_stage_pkg::DEFAULT_CTRL_W
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [1:0]        count_o;

  modport slave (
    input  in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_ctrl_o, count_o
  );

  modport master (
    output in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o, count_o
  );
endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - pipeline register stage: two-entry skid buffer (SKID=1) or
// single register with combinational ready (SKID=0), with flush.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SKID   = 1
) (
  input logic       clk,
  input logic       rst,
  input logic       flush_i,
  pipe_stage_if.slave bus
);

  logic [1:0]        r_count;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_head_data;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic       w_out_valid;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_consume;
  logic [1:0] w_count_nxt;
  logic       w_load_head_in;
  logic       w_load_head_skid;
  logic       w_load_skid;
  logic       w_clr_head;

  assign w_out_valid = (r_count != ST_EMPTY);
  // The skid variant breaks the ready path; the plain variant forwards it
  assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || bus.out_ready_i);
  assign w_accept    = bus.in_valid_i && w_in_ready;
  assign w_consume   = w_out_valid && bus.out_ready_i;

  always_comb begin
    w_count_nxt      = r_count;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_head       = 1'b0;
    case (r_count)
      ST_EMPTY: begin
        if (w_accept) begin
          w_count_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_consume) begin
          w_load_head_in = 1'b1;
        end else if (w_accept) begin
          w_count_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_consume) begin
          w_count_nxt = ST_EMPTY;
          w_clr_head  = 1'b1;
        end
      end
      ST_TWO: begin
        if (w_consume) begin
          w_count_nxt      = ST_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: begin
        w_count_nxt = ST_EMPTY;
        w_clr_head  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_head_data <= '0;
      r_head_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush_i) begin
      r_count     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_head_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != ST_TWO);
      if (w_load_head_in) begin
        r_head_data <= bus.in_data_i;
        r_head_ctrl <= bus.in_ctrl_i;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_ctrl <= r_skid_ctrl;
        r_skid_ctrl <= '0;
      end else if (w_clr_head) begin
        r_head_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_data <= bus.in_data_i;
        r_skid_ctrl <= bus.in_ctrl_i;
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = r_head_data;
  assign bus.out_ctrl_o  = r_head_ctrl;
  assign bus.count_o     = r_count;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - scoreboard bench for pipe_stage, SKID=1 and SKID=0 instances
module tb_pipe_stage;
  localparam int DW = 96;
  localparam int CW = 8;

  logic clk;
  logic rst;
  logic flush_a;
  logic flush_b;

  pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW)) a_if ();
  pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW)) b_if ();

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush_i(flush_a), .bus(a_if.slave)
  );
  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .flush_i(flush_b), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW+CW-1:0] sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the skid instance: expectations queued at accept, checked at consume
  always @(negedge clk) begin
    logic [DW+CW-1:0] exp_e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (a_if.out_valid_o && a_if.out_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", {a_if.out_data_o, a_if.out_ctrl_o}, '1);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_out_entry", {a_if.out_data_o, a_if.out_ctrl_o}, exp_e);
        end
      end
      if (!a_if.out_valid_o)
        chk("sb_bubble_ctrl", a_if.out_ctrl_o, 0);
      if (flush_a)
        sb_q.delete();
      else if (a_if.in_valid_i && a_if.in_ready_o)
        sb_q.push_back({a_if.in_data_i, a_if.in_ctrl_i});
      if (b_if.count_o > 2'd1)
        chk("b_count_le1", b_if.count_o, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    a_if.in_valid_i = v;
    a_if.in_data_i  = d;
    a_if.in_ctrl_i  = c;
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_a(1'b0, '0, '0);
    a_if.out_ready_i = 1'b0;
    b_if.in_valid_i  = 1'b0;
    b_if.in_data_i   = '0;
    b_if.in_ctrl_i   = '0;
    b_if.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", a_if.out_valid_o, 0);
    chk("rst_ctrl", a_if.out_ctrl_o, 0);
    chk("rst_data", a_if.out_data_o, 0);
    chk("rst_count", a_if.count_o, 0);
    chk("rst_in_ready", a_if.in_ready_o, 1);

    // Streaming 1..5 at full rate
    a_if.out_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive_a(1'b1, DW'(i), CW'(8'h40 | i));
      step();
      chk("stream_valid", a_if.out_valid_o, 1);
      chk("stream_data", a_if.out_data_o, i);
      chk("stream_ctrl", a_if.out_ctrl_o, 8'h40 | i);
      chk("stream_count", a_if.count_o, 1);
    end
    drive_a(1'b0, '0, '0);
    step();
    chk("stream_drain_count", a_if.count_o, 0);
    chk("stream_drain_ctrl", a_if.out_ctrl_o, 0);

    // Backpressure
    a_if.out_ready_i = 1'b0;
    drive_a(1'b1, 96'hAA, 8'h01);
    step();
    drive_a(1'b1, 96'hBB, 8'h41);
    step();
    chk("bp_count2", a_if.count_o, 2);
    chk("bp_in_ready", a_if.in_ready_o, 0);
    chk("bp_head", a_if.out_data_o, 96'hAA);
    drive_a(1'b0, '0, '0);
    step();
    chk("bp_head_stable", a_if.out_data_o, 96'hAA);
    chk("bp_ctrl_stable", a_if.out_ctrl_o, 8'h01);
    a_if.out_ready_i = 1'b1;
    step();
    chk("bp_second", a_if.out_data_o, 96'hBB);
    chk("bp_count1", a_if.count_o, 1);
    chk("bp_in_ready_back", a_if.in_ready_o, 1);
    step();
    chk("bp_empty", a_if.out_valid_o, 0);

    // Flush with count 2 and a competing input
    a_if.out_ready_i = 1'b0;
    drive_a(1'b1, 96'hAA, 8'h11);
    step();
    drive_a(1'b1, 96'hBB, 8'h22);
    step();
    chk("fl_pre_count", a_if.count_o, 2);
    drive_a(1'b1, 96'hCC, 8'h33);
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    drive_a(1'b0, '0, '0);
    chk("fl_count", a_if.count_o, 0);
    chk("fl_valid", a_if.out_valid_o, 0);
    chk("fl_ctrl", a_if.out_ctrl_o, 0);
    chk("fl_in_ready", a_if.in_ready_o, 1);
    a_if.out_ready_i = 1'b1;
    step();
    chk("fl_no_c", a_if.out_valid_o, 0);

    // Flush coinciding with a consume
    a_if.out_ready_i = 1'b0;
    drive_a(1'b1, 96'h55, 8'h05);
    step();
    drive_a(1'b1, 96'h66, 8'h06);
    step();
    drive_a(1'b0, '0, '0);
    a_if.out_ready_i = 1'b1;
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    chk("flc_count", a_if.count_o, 0);
    chk("flc_valid", a_if.out_valid_o, 0);

    // Accept and consume together in ONE
    drive_a(1'b1, 96'h11, 8'h81);
    step();
    drive_a(1'b1, 96'h22, 8'h82);
    step();
    chk("sim_head", a_if.out_data_o, 96'h22);
    chk("sim_ctrl", a_if.out_ctrl_o, 8'h82);
    chk("sim_count", a_if.count_o, 1);

    // Reset mid-operation
    a_if.out_ready_i = 1'b0;
    drive_a(1'b1, 96'h77, 8'h07);
    step();
    drive_a(1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_count", a_if.count_o, 0);
    chk("mrst_valid", a_if.out_valid_o, 0);
    chk("mrst_data", a_if.out_data_o, 0);
    chk("mrst_ctrl", a_if.out_ctrl_o, 0);
    chk("mrst_in_ready", a_if.in_ready_o, 1);
    a_if.out_ready_i = 1'b1;
    step();
    chk("mrst_no_ghost", a_if.out_valid_o, 0);

    // SKID=0 instance
    chk("b_rst_in_ready", b_if.in_ready_o, 1);
    b_if.in_valid_i = 1'b1;
    b_if.in_data_i  = 96'h33;
    b_if.in_ctrl_i  = 8'h03;
    step();
    chk("b_full_count", b_if.count_o, 1);
    chk("b_full_data", b_if.out_data_o, 96'h33);
    chk("b_full_in_ready", b_if.in_ready_o, 0);
    b_if.in_data_i  = 96'h44;
    b_if.in_ctrl_i  = 8'h04;
    step();
    chk("b_held", b_if.out_data_o, 96'h33);
    b_if.out_ready_i = 1'b1;
    #1;
    chk("b_comb_ready", b_if.in_ready_o, 1);
    step();
    chk("b_replaced", b_if.out_data_o, 96'h44);
    chk("b_replaced_ctrl", b_if.out_ctrl_o, 8'h04);
    chk("b_count", b_if.count_o, 1);
    b_if.in_valid_i = 1'b0;
    step();
    chk("b_empty_valid", b_if.out_valid_o, 0);
    chk("b_empty_ctrl", b_if.out_ctrl_o, 0);

    step();
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
